// File: rtl/pipeline_fetch_stage.sv
// Stage-0 instruction fetch front end: IR + one-entry skid, bus-steal FSM,
// and one-hot PC increment strobes for NUM_PC address registers.
//   state  | meaning
//   RUN    | normal fetch, bubble on request/suppress mismatch
//   STEAL  | external master owns the bus, DMA PC advances
//   RESUME | turnaround, held instruction re-presented once
module pipeline_fetch_stage #(
  parameter int               WIDTH  = 8,
  parameter int               NUM_PC = 2,
  parameter int               DMA_PC = 1,
  parameter logic [WIDTH-1:0] NOP    = '0,
  parameter int               CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          bus_in,
  input  logic                      load_bus,
  input  logic                      bus_request,
  input  logic                      fetch_suppress,
  input  logic [$clog2(NUM_PC)-1:0] pc_sel,
  input  logic                      stall,
  input  logic                      flush,
  output logic [WIDTH-1:0]          instruction_out,
  output logic                      instr_valid,
  output logic [NUM_PC-1:0]         inc_pc,
  output logic [CNT_W-1:0]          steal_cycles,
  output logic                      overrun,
  output logic [1:0]                state
);

  localparam int PC_W = $clog2(NUM_PC);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STEAL  = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t            st, st_nxt;
  logic [WIDTH-1:0]  ir, ir_nxt;
  logic              valid, valid_nxt;
  logic [WIDTH-1:0]  skid, skid_nxt;
  logic              skid_full, skid_full_nxt;
  logic              ovr, ovr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              fetch_inc, dma_inc;
  logic              steal, mismatch;

  assign steal    = bus_request & fetch_suppress;
  assign mismatch = bus_request ^ fetch_suppress;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RUN;
      ir        <= NOP;
      valid     <= 1'b0;
      skid      <= '0;
      skid_full <= 1'b0;
      ovr       <= 1'b0;
      cnt       <= '0;
    end else begin
      st        <= st_nxt;
      ir        <= ir_nxt;
      valid     <= valid_nxt;
      skid      <= skid_nxt;
      skid_full <= skid_full_nxt;
      ovr       <= ovr_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt        = st;
    ir_nxt        = ir;
    valid_nxt     = valid;
    skid_nxt      = skid;
    skid_full_nxt = skid_full;
    ovr_nxt       = ovr;
    cnt_nxt       = cnt;
    fetch_inc     = 1'b0;
    dma_inc       = 1'b0;
    if (flush) begin
      ir_nxt        = NOP;
      valid_nxt     = 1'b0;
      skid_full_nxt = 1'b0;
      st_nxt        = RUN;
    end else begin
      unique case (st)
        RUN: begin
          if (steal) begin
            // the bus already belongs to the external master this cycle
            st_nxt    = STEAL;
            cnt_nxt   = CNT_W'(1);
            valid_nxt = 1'b0;
            dma_inc   = load_bus;
          end else if (mismatch) begin
            ir_nxt    = NOP;
            valid_nxt = 1'b1;
          end else if (stall) begin
            if (load_bus) begin
              if (!skid_full) begin
                skid_nxt      = bus_in;
                skid_full_nxt = 1'b1;
                fetch_inc     = 1'b1;
              end else begin
                ovr_nxt = 1'b1;
              end
            end
          end else if (skid_full) begin
            ir_nxt    = skid;
            valid_nxt = 1'b1;
            // a byte arriving while draining refills the skid so nothing is lost
            if (load_bus) begin
              skid_nxt  = bus_in;
              fetch_inc = 1'b1;
            end else begin
              skid_full_nxt = 1'b0;
            end
          end else if (load_bus) begin
            ir_nxt    = bus_in;
            valid_nxt = 1'b1;
            fetch_inc = 1'b1;
          end else begin
            valid_nxt = 1'b0;
          end
        end
        STEAL: begin
          valid_nxt = 1'b0;
          dma_inc   = load_bus;
          if (bus_request) begin
            if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + CNT_W'(1);
          end else begin
            st_nxt = RESUME;
          end
        end
        RESUME: begin
          if (!stall) begin
            valid_nxt = 1'b1;
            st_nxt    = RUN;
          end
        end
        default: st_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    inc_pc = '0;
    if (rst_n) begin
      for (int i = 0; i < NUM_PC; i++) begin
        inc_pc[i] = (fetch_inc && (pc_sel == PC_W'(i))) || (dma_inc && (DMA_PC == i));
      end
    end
  end

  assign instruction_out = ir;
  assign instr_valid     = valid;
  assign steal_cycles    = cnt;
  assign overrun         = ovr;
  assign state           = st;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Directed bench for pipeline_fetch_stage; a second instance with CNT_W=2
// shares the stimulus to exercise steal counter saturation.
module tb_pipeline_fetch_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       load_bus, bus_request, fetch_suppress, stall, flush;
  logic [0:0] pc_sel;

  logic [7:0] instruction_out, s_instruction_out;
  logic       instr_valid, s_instr_valid;
  logic [1:0] inc_pc, s_inc_pc;
  logic [7:0] steal_cycles;
  logic [1:0] s_steal_cycles;
  logic       overrun, s_overrun;
  logic [1:0] state, s_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .load_bus(load_bus),
    .bus_request(bus_request), .fetch_suppress(fetch_suppress), .pc_sel(pc_sel),
    .stall(stall), .flush(flush), .instruction_out(instruction_out),
    .instr_valid(instr_valid), .inc_pc(inc_pc), .steal_cycles(steal_cycles),
    .overrun(overrun), .state(state)
  );

  pipeline_fetch_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .load_bus(load_bus),
    .bus_request(bus_request), .fetch_suppress(fetch_suppress), .pc_sel(pc_sel),
    .stall(stall), .flush(flush), .instruction_out(s_instruction_out),
    .instr_valid(s_instr_valid), .inc_pc(s_inc_pc), .steal_cycles(s_steal_cycles),
    .overrun(s_overrun), .state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lb, input logic [7:0] b, input logic br,
                       input logic fs, input logic st, input logic fl);
    load_bus = lb; bus_in = b; bus_request = br; fetch_suppress = fs;
    stall = st; flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ir, input logic v,
                         input logic [1:0] s);
    chk({tag, "_ir"}, 32'(instruction_out), 32'(ir));
    chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
    chk({tag, "_state"}, 32'(state), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0; pc_sel = 1'b0;
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    chk_out("reset", 8'h00, 1'b0, 2'd0);
    chk("reset_inc", 32'(inc_pc), 32'd0);
    chk("reset_cnt", 32'(steal_cycles), 32'd0);
    chk("reset_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    // stream 0x11, 0x22, 0x33
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_inc", 32'(inc_pc), 32'b01);
    step(); chk_out("s1", 8'h11, 1'b1, 2'd0);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2_inc", 32'(inc_pc), 32'b01);
    step(); chk_out("s2", 8'h22, 1'b1, 2'd0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s3_inc", 32'(inc_pc), 32'b01);
    step(); chk_out("s3", 8'h33, 1'b1, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_inc", 32'(inc_pc), 32'd0);
    step(); chk_out("idle", 8'h33, 1'b0, 2'd0);

    // stall: 0x44 into skid, 0x55 dropped
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sk1_inc", 32'(inc_pc), 32'b01);
    step(); chk_out("sk1", 8'h33, 1'b0, 2'd0);
    chk("sk1_ovr", 32'(overrun), 32'd0);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sk2_inc", 32'(inc_pc), 32'd0);
    step(); chk("sk2_ovr", 32'(overrun), 32'd1);
    chk("sk2_ir", 32'(instruction_out), 32'h33);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("drain", 8'h44, 1'b1, 2'd0);
    step(); chk_out("drain_idle", 8'h44, 1'b0, 2'd0);

    // bubble on mismatch
    drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bub_inc", 32'(inc_pc), 32'd0);
    step(); chk_out("bub", 8'h00, 1'b1, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("bub_after", 8'h00, 1'b0, 2'd0);

    // steal for 4 cycles with IR=0x22
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("pre_steal", 8'h22, 1'b1, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("st%0d_inc", i), 32'(inc_pc), 32'b10);
      step();
      chk_out($sformatf("st%0d", i), 8'h22, 1'b0, 2'd1);
      chk($sformatf("st%0d_cnt", i), 32'(steal_cycles), 32'(i));
    end
    chk("st_sat4", 32'(s_steal_cycles), 32'd3);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("st_exit_inc", 32'(inc_pc), 32'd0);
    step(); chk_out("resume", 8'h22, 1'b0, 2'd2);
    chk("resume_cnt", 32'(steal_cycles), 32'd4);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_inc", 32'(inc_pc), 32'd0);
    step(); chk_out("replay", 8'h22, 1'b1, 2'd0);
    chk("replay_cnt", 32'(steal_cycles), 32'd4);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("post_replay", 8'h22, 1'b0, 2'd0);

    // 6-cycle steal without bus traffic, then stall through RESUME
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    chk("sat6_cnt", 32'(s_steal_cycles), 32'd3);
    chk("full6_cnt", 32'(steal_cycles), 32'd6);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_out("rs_stall1", 8'h22, 1'b0, 2'd2);
    step(); chk_out("rs_stall2", 8'h22, 1'b0, 2'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("rs_go", 8'h22, 1'b1, 2'd0);
    chk("rs_cnt", 32'(steal_cycles), 32'd6);

    // flush during stall with skid full
    drive(1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk("fl_pre_ovr", 32'(overrun), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fl_inc", 32'(inc_pc), 32'd0);
    step(); chk_out("flush", 8'h00, 1'b0, 2'd0);
    chk("flush_ovr", 32'(overrun), 32'd1);
    chk("flush_cnt", 32'(steal_cycles), 32'd6);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("skid_empty", 8'h00, 1'b0, 2'd0);

    // flush beats steal, steal taken next cycle
    drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flst_inc", 32'(inc_pc), 32'd0);
    step(); chk("flst_state", 32'(state), 32'd0);
    drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk("flst_next", 32'(state), 32'd1);
    chk("flst_cnt", 32'(steal_cycles), 32'd1);
    step(); chk("mid_cnt", 32'(steal_cycles), 32'd2);

    // async reset mid-steal
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 8'h00, 1'b0, 2'd0);
    chk("mid_rst_cnt", 32'(steal_cycles), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_inc", 32'(inc_pc), 32'd0);
    #2;
    rst_n = 1'b1;

    // fetch through PC 1
    pc_sel = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc1_inc", 32'(inc_pc), 32'b10);
    step(); chk_out("pc1", 8'h5A, 1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch_stage.md
Name: pipeline_fetch_stage

Overview:
Parametrised stage-0 instruction fetch front end. Registers instruction bytes from the memory bus into an instruction register (IR), presents them to decode with a valid flag, and absorbs one in-flight byte in a skid register when decode stalls. It handles bus steals by an external master with a small FSM and generates one-hot program-counter increment strobes for NUM_PC address registers. Sits between the memory bus and the stage-1 decoder.

Parameters:
WIDTH, 8, instruction/bus width in bits
NUM_PC, 2, number of PC/address registers driven by inc_pc (>=2)
DMA_PC, 1, index of the PC register advanced during bus steals
NOP, 0, WIDTH-bit opcode injected as a bubble
CNT_W, 8, width of steal-cycle counter

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
bus_in  in  WIDTH  memory data bus
load_bus  in  1  bus_in holds a valid byte this cycle
bus_request  in  1  external master requests the bus
fetch_suppress  in  1  control asks fetch to stand off
pc_sel  in  $clog2(NUM_PC)  PC register used for instruction fetch
stall  in  1  decoder cannot accept instruction_out this cycle
flush  in  1  synchronous pipeline flush
instruction_out  out  WIDTH  IR contents to decode
instr_valid  out  1  instruction_out is a new instruction
inc_pc  out  NUM_PC  one-hot PC increment strobes, combinational
steal_cycles  out  CNT_W  length of current/last steal, saturating
overrun  out  1  sticky: byte lost while skid full
state  out  2  FSM state: RUN=0, STEAL=1, RESUME=2

Behaviour:
- Reset (rst_n=0, async): state=RUN, IR=NOP, instr_valid=0, skid empty, steal_cycles=0, overrun=0. inc_pc=0 while in reset.
- Priority each edge: reset > flush > steal handling > stall/skid > normal fetch.
- steal = bus_request & fetch_suppress. mismatch = bus_request ^ fetch_suppress.
- RUN, no stall, no steal, no mismatch:
  - If skid full: IR<=skid, skid emptied, instr_valid<=1.
  - Else if load_bus: IR<=bus_in, instr_valid<=1.
  - Else instr_valid<=0, IR held.
  - inc_pc[pc_sel]=1 in the same cycle whenever a bus byte is accepted into IR or skid.
- RUN, mismatch: bubble. IR<=NOP, instr_valid<=1, no inc_pc, and load_bus is ignored. If the skid is full, it is retained.
- RUN, stall: IR and instr_valid hold.
  - If load_bus and skid empty: skid<=bus_in, inc_pc[pc_sel]=1.
  - If load_bus and skid full: byte dropped, overrun<=1, no inc_pc.
- RUN, steal: next state=STEAL, steal_cycles<=1. IR holds (replay of the current instruction after resume), instr_valid<=0. The stall path is overridden.
- STEAL:
  - instr_valid=0 and IR held.
  - inc_pc[DMA_PC]=1 on every cycle with load_bus=1. Fetch PCs do not increment and bus_in is not captured.
  - steal_cycles increments and saturates at 2^CNT_W-1.
  - Leave to RESUME when bus_request=0 (fetch_suppress ignored).
- RESUME: one turnaround cycle. instr_valid<=1 with IR unchanged (held instruction re-presented once), no inc_pc, load_bus ignored. Next state=RUN. steal_cycles holds its final value until the next steal.
- Stall in RESUME: stay in RESUME until stall=0. The re-present occurs on the first non-stalled cycle.
- flush: IR<=NOP, instr_valid<=0, skid emptied, state=RUN, no inc_pc. overrun and steal_cycles are preserved.
- Simultaneous flush and steal: flush wins, state=RUN. The steal is taken next cycle if still asserted.
- Reset mid-steal returns to RUN immediately. Any partial steal count is lost.
- inc_pc is never multi-hot. pc_sel >= NUM_PC produces inc_pc=0.

Test Plan:
- Reset then stream: load_bus=1, bus_in=0x11,0x22,0x33, pc_sel=0 -> instruction_out 0x11,0x22,0x33 on consecutive cycles, one cycle after each input; instr_valid=1; inc_pc=2'b01 for three cycles.
- Stall skid: stall=1 for 2 cycles while load_bus delivers 0x44,0x55 -> 0x44 goes to skid, 0x55 is dropped, overrun=1; after stall=0, instruction_out=0x44.
- Bubble: bus_request=1, fetch_suppress=0 for 1 cycle with bus_in=0x66 -> instruction_out=NOP, instr_valid=1, inc_pc=0; 0x66 is not captured.
- Steal: IR=0x22, steal for 4 cycles with load_bus=1 -> state=STEAL, inc_pc=2'b10 for each of the 4 cycles, instr_valid=0, steal_cycles=4; then RESUME re-presents 0x22 with instr_valid=1, then RUN.
- Saturation: CNT_W=2, steal lasting 6 cycles -> steal_cycles=3.
- Flush during stall with skid full -> next cycle instruction_out=NOP, instr_valid=0, skid empty, overrun unchanged; async rst_n pulse mid-STEAL -> state=RUN immediately, all outputs at reset values.
